// File: rtl/param_shift_reg_pkg.sv
// rtl/param_shift_reg_pkg.sv - mode encoding and count-width helper for param_shift_reg
//   mode_e      : HOLD / SHR / SHL / LOAD operation codes carried on the mode bus
//   count_width : bits needed to hold an occupancy value 0..depth
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/param_shift_reg_if.sv
// rtl/param_shift_reg_if.sv - control, data and status bundle of param_shift_reg
//   master : drives en/mode/rotate/flush/sin/pin, observes pout/msb_out/lsb_out/count/full
//   slave  : the shift register side of the same signals
interface param_shift_reg_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  import shift_pkg::*;

  localparam int CW = count_width(DEPTH);

  logic                   en;
  logic [1:0]             mode;
  logic                   rotate;
  logic                   flush;
  logic [WIDTH-1:0]       sin;
  logic [WIDTH*DEPTH-1:0] pin;
  logic [WIDTH*DEPTH-1:0] pout;
  logic [WIDTH-1:0]       msb_out;
  logic [WIDTH-1:0]       lsb_out;
  logic [CW-1:0]          count;
  logic                   full;

  modport master (
    output en, mode, rotate, flush, sin, pin,
    input  pout, msb_out, lsb_out, count, full
  );

  modport slave (
    input  en, mode, rotate, flush, sin, pin,
    output pout, msb_out, lsb_out, count, full
  );

endinterface

// File: rtl/param_shift_reg_sat_counter.sv
// rtl/param_shift_reg_sat_counter.sv - saturating occupancy counter with full flag
//   clk, reset : clock and synchronous active-high reset
//   clear      : force count to 0 (wins over load_max and inc)
//   load_max   : force count to MAX
//   inc        : increment, sticking at MAX
//   count, full: registered occupancy and (count == MAX)
module sat_counter #(
  parameter int MAX = 4,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load_max,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          full
);

  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] count_d, count_q;
  logic          full_d, full_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load_max) begin
      count_d = MAX_V;
    end else if (inc && (count_q != MAX_V)) begin
      count_d = count_q + CW'(1);
    end
    // full is kept as its own flop so the output stays a pure register view
    full_d = (count_d == MAX_V);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;

endmodule

// File: rtl/param_shift_reg.sv
// rtl/param_shift_reg.sv - parameterised bidirectional shift register with rotate, load and occupancy
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of param_shift_reg_if (controls, serial/parallel data, status)
module param_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  param_shift_reg_if.slave  bus
);

  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0]       stage_d [DEPTH];
  logic [WIDTH-1:0]       stage_q [DEPTH];
  logic [WIDTH*DEPTH-1:0] pout_w;
  logic                   cnt_load;
  logic                   cnt_inc;
  mode_e                  mode_s;

  assign mode_s = mode_e'(bus.mode);

  always_comb begin
    stage_d  = stage_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) stage_d[k] = '0;
    end else if (bus.en) begin
      case (mode_s)
        MODE_SHR: begin
          for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
          stage_d[0] = bus.rotate ? stage_q[DEPTH-1] : bus.sin;
          // a rotated element is not new, so occupancy only grows from sin
          cnt_inc    = ~bus.rotate;
        end
        MODE_SHL: begin
          for (int k = 0; k < DEPTH-1; k++) stage_d[k] = stage_q[k+1];
          stage_d[DEPTH-1] = bus.rotate ? stage_q[0] : bus.sin;
          cnt_inc          = ~bus.rotate;
        end
        MODE_LOAD: begin
          for (int k = 0; k < DEPTH; k++) stage_d[k] = bus.pin[k*WIDTH +: WIDTH];
          cnt_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
    end
  end

  sat_counter #(
    .MAX (DEPTH),
    .CW  (CW)
  ) u_count (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.flush),
    .load_max (cnt_load),
    .inc      (cnt_inc),
    .count    (bus.count),
    .full     (bus.full)
  );

  always_comb begin
    pout_w = '0;
    for (int k = 0; k < DEPTH; k++) pout_w[k*WIDTH +: WIDTH] = stage_q[k];
  end

  assign bus.pout    = pout_w;
  assign bus.msb_out = stage_q[DEPTH-1];
  assign bus.lsb_out = stage_q[0];

endmodule

// File: tb/tb_param_shift_reg.sv
// tb/tb_param_shift_reg.sv - scoreboard bench for three param_shift_reg configurations
module tb_param_shift_reg;

  typedef struct packed {
    logic [1:0]  dut;
    logic [31:0] pout;
    logic [7:0]  msb;
    logic [7:0]  lsb;
    logic [7:0]  cnt;
    logic        full;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  param_shift_reg_if #(.WIDTH(1), .DEPTH(4)) ifa ();
  param_shift_reg_if #(.WIDTH(8), .DEPTH(4)) ifb ();
  param_shift_reg_if #(.WIDTH(4), .DEPTH(1)) ifc ();

  param_shift_reg #(.WIDTH(1), .DEPTH(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  param_shift_reg #(.WIDTH(8), .DEPTH(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  param_shift_reg #(.WIDTH(4), .DEPTH(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  int n_assert = 0;
  int n_fail   = 0;

  exp_t  exp_q[$];
  string tag_q[$];

  int          wv[3] = '{1, 8, 4};
  int          dv[3] = '{4, 4, 1};
  logic [63:0] m_vec[3];
  int          m_cnt[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t observe(input int id);
    exp_t o;
    o = '0;
    o.dut = 2'(id);
    case (id)
      0: begin o.pout = 32'(ifa.pout); o.msb = 8'(ifa.msb_out); o.lsb = 8'(ifa.lsb_out);
               o.cnt = 8'(ifa.count); o.full = ifa.full; end
      1: begin o.pout = 32'(ifb.pout); o.msb = 8'(ifb.msb_out); o.lsb = 8'(ifb.lsb_out);
               o.cnt = 8'(ifb.count); o.full = ifb.full; end
      default: begin o.pout = 32'(ifc.pout); o.msb = 8'(ifc.msb_out); o.lsb = 8'(ifc.lsb_out);
               o.cnt = 8'(ifc.count); o.full = ifc.full; end
    endcase
    return o;
  endfunction

  // Reference model works on the packed vector as a whole (shift by WIDTH bits)
  task automatic model(input int j, input logic rst, input logic en, input logic [1:0] mode,
                       input logic rot, input logic fl, input logic [7:0] s, input logic [31:0] p);
    logic [63:0] em, tm, sh, v;
    int w, d;
    w  = wv[j];
    d  = dv[j];
    em = (64'd1 << w) - 64'd1;
    tm = (64'd1 << (w * d)) - 64'd1;
    v  = m_vec[j];
    if (rst || fl) begin
      v = '0;
      m_cnt[j] = 0;
    end else if (en) begin
      case (mode)
        2'b01: begin
          sh = rot ? ((v >> (w * (d - 1))) & em) : (64'(s) & em);
          v  = ((v << w) | sh) & tm;
          if (!rot && m_cnt[j] < d) m_cnt[j]++;
        end
        2'b10: begin
          sh = rot ? (v & em) : (64'(s) & em);
          v  = ((v >> w) | (sh << (w * (d - 1)))) & tm;
          if (!rot && m_cnt[j] < d) m_cnt[j]++;
        end
        2'b11: begin
          v = 64'(p) & tm;
          m_cnt[j] = d;
        end
        default: ;
      endcase
    end
    m_vec[j] = v;
  endtask

  task automatic step(input int id, input logic rst, input logic en, input logic [1:0] mode,
                      input logic rot, input logic fl, input logic [7:0] s, input logic [31:0] p,
                      input string tag);
    exp_t e, o;
    @(negedge clk);
    reset = rst;
    ifa.en = 1'b0; ifa.mode = 2'b00; ifa.rotate = 1'b0; ifa.flush = 1'b0; ifa.sin = s[0];   ifa.pin = p[3:0];
    ifb.en = 1'b0; ifb.mode = 2'b00; ifb.rotate = 1'b0; ifb.flush = 1'b0; ifb.sin = s;      ifb.pin = p;
    ifc.en = 1'b0; ifc.mode = 2'b00; ifc.rotate = 1'b0; ifc.flush = 1'b0; ifc.sin = s[3:0]; ifc.pin = p[3:0];
    case (id)
      0: begin ifa.en = en; ifa.mode = mode; ifa.rotate = rot; ifa.flush = fl; end
      1: begin ifb.en = en; ifb.mode = mode; ifb.rotate = rot; ifb.flush = fl; end
      default: begin ifc.en = en; ifc.mode = mode; ifc.rotate = rot; ifc.flush = fl; end
    endcase
    for (int j = 0; j < 3; j++) begin
      if (j == id) model(j, rst, en, mode, rot, fl, s, p);
      else         model(j, rst, 1'b0, 2'b00, 1'b0, 1'b0, s, p);
      e      = '0;
      e.dut  = 2'(j);
      e.pout = m_vec[j][31:0];
      e.msb  = 8'((m_vec[j] >> (wv[j] * (dv[j] - 1))) & ((64'd1 << wv[j]) - 64'd1));
      e.lsb  = 8'(m_vec[j] & ((64'd1 << wv[j]) - 64'd1));
      e.cnt  = 8'(m_cnt[j]);
      e.full = (m_cnt[j] == dv[j]);
      exp_q.push_back(e);
      tag_q.push_back($sformatf("%s/dut%0d", tag, j));
    end
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = observe(int'(e.dut));
      chk({t, ".pout"},  o.pout,        e.pout);
      chk({t, ".msb"},   32'(o.msb),    32'(e.msb));
      chk({t, ".lsb"},   32'(o.lsb),    32'(e.lsb));
      chk({t, ".count"}, 32'(o.cnt),    32'(e.cnt));
      chk({t, ".full"},  32'(o.full),   32'(e.full));
    end
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin m_vec[j] = '0; m_cnt[j] = 0; end

    // reset overrides an enabled shift on the same edge
    step(0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h01, 32'h0, "reset");
    chk("reset_a_pout", 32'(ifa.pout), 32'h0);

    // W1 D4: serial fill from sin
    for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h01, 32'h0, $sformatf("a_shr%0d", i));
    chk("a_fill_pout", 32'(ifa.pout), 32'hF);
    chk("a_fill_msb",  32'(ifa.msb_out), 32'h1);
    chk("a_fill_full", 32'(ifa.full), 32'h1);
    step(0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 32'h0, "a_shl0");
    step(0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 32'h0, "a_shr_rot");
    step(0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h01, 32'h0, "a_hold");
    step(0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h01, 32'h0, "a_en0");

    // W8 D4: load and rotate both ways
    step(1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 32'h44332211, "b_load");
    step(1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 32'h0, "b_shr_rot");
    chk("b_rotr_pout", ifb.pout, 32'h33221144);
    chk("b_rotr_cnt",  32'(ifb.count), 32'd4);
    step(1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h00, 32'h0, "b_shl_rot");
    chk("b_rotl_pout", ifb.pout, 32'h44332211);

    // saturation from an empty register
    step(1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 32'h0, "b_flush");
    for (int i = 0; i < 6; i++) step(1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'hA5, 32'h0, $sformatf("b_sat%0d", i));
    chk("b_sat_cnt",  32'(ifb.count), 32'd4);
    chk("b_sat_full", 32'(ifb.full), 32'd1);
    chk("b_sat_pout", ifb.pout, 32'hA5A5A5A5);

    // flush beats a same-edge load
    step(1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 8'h00, 32'hDEADBEEF, "b_flush_load");
    chk("b_fl_pout", ifb.pout, 32'h0);
    chk("b_fl_cnt",  32'(ifb.count), 32'd0);

    // reset in the middle of a shift stream, then idle cycles
    step(1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h3C, 32'h0, "b_stream0");
    step(1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'hC3, 32'h0, "b_stream1");
    step(1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h77, 32'h0, "b_reset_mid");
    chk("b_rst_pout", ifb.pout, 32'h0);
    step(1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h77, 32'h0, "b_idle0");
    step(1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 8'h77, 32'h12345678, "b_idle1");
    step(1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h81, 32'h0, "b_first_after_rst");

    // W4 D1: single stage replace and rotate-hold
    step(2, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h09, 32'h0, "c_shl");
    chk("c_lsb",  32'(ifc.lsb_out), 32'h9);
    chk("c_msb",  32'(ifc.msb_out), 32'h9);
    chk("c_full", 32'(ifc.full), 32'h1);
    step(2, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h05, 32'h0, "c_shl_rot");
    chk("c_rot_lsb", 32'(ifc.lsb_out), 32'h9);
    step(2, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h03, 32'h0, "c_shr");
    step(2, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 32'h6, "c_load");

    // back-to-back mode changes with no idle edge
    step(0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 8'h01, 32'h0, "a_mc_shr");
    step(0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 32'h0, "a_mc_shl");
    step(0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 32'h5, "a_mc_load");
    step(0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 32'h0, "a_mc_rot");
    chk("a_mc_pout", 32'(ifa.pout), 32'hA);

    // random mix across all three instances
    for (int i = 0; i < 40; i++) begin
      int id;
      id = int'($urandom_range(0, 2));
      step(id, ($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom), 1'($urandom),
           ($urandom_range(0, 9) == 0), 8'($urandom), $urandom, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/param_shift_reg.md
PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 Parameter WIDTH, default 1: bits per stage (element), >= 1.
REQ-002 Parameter DEPTH, default 4: number of stages, >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  operation enable; 0 = hold everything except flush/reset.
REQ-006 mode  input  2  00 HOLD, 01 SHR (toward stage DEPTH-1), 10 SHL (toward stage 0), 11 LOAD.
REQ-007 rotate  input  1  during SHR/SHL, the element leaving the register re-enters at the opposite end instead of sin.
REQ-008 flush  input  1  clear all stages and occupancy.
REQ-009 sin  input  WIDTH  serial element input.
REQ-010 pin  input  WIDTH*DEPTH  parallel load data; stage k = pin[k*WIDTH +: WIDTH].
REQ-011 pout  output  WIDTH*DEPTH  all stages, same packing as pin.
REQ-012 msb_out  output  WIDTH  stage DEPTH-1 (SHR serial out).
REQ-013 lsb_out  output  WIDTH  stage 0 (SHL serial out).
REQ-014 count  output  $clog2(DEPTH+1)  occupancy: elements shifted in since last reset/flush, saturating.
REQ-015 full  output  1  count == DEPTH.

Function
REQ-016 Priority per edge: reset > flush > (en & mode) > hold.
REQ-017 SHR: stage[k] <= stage[k-1] for k >= 1; stage[0] <= rotate ? stage[DEPTH-1] : sin.
REQ-018 SHL: stage[k] <= stage[k+1] for k < DEPTH-1; stage[DEPTH-1] <= rotate ? stage[0] : sin.
REQ-019 LOAD: all stages <= pin in one cycle; count <= DEPTH.
REQ-020 HOLD or en=0: stages and count unchanged.
REQ-021 Shift without rotate: count <= min(count+1, DEPTH); no wrap-around past DEPTH.
REQ-022 Shift with rotate: count unchanged (no new element enters).
REQ-023 flush: stages <= 0, count <= 0 at that edge, regardless of en/mode.
REQ-024 Latency: sin captured on an enabled SHR edge appears on msb_out after exactly DEPTH enabled SHR edges (first at stage 0 after 1 edge); symmetric for SHL/lsb_out.
REQ-025 All outputs are direct register views; no combinational path from any input to any output.
REQ-026 DEPTH=1: SHR/SHL replace the single stage; rotate leaves it unchanged.
REQ-027 Mode change between cycles takes effect on the next edge with no idle cycle.

Reset
REQ-028 On reset edge: all stages 0, count 0, full 0; pout, msb_out, lsb_out all 0 from the following cycle.
REQ-029 Reset asserted mid-operation (any mode, en high) overrides that cycle's operation completely.
REQ-030 After reset deassertion, the first enabled edge performs its operation normally.

Structure
REQ-031 Package shift_pkg holds the mode encoding typedef (HOLD/SHR/SHL/LOAD) and count-width function.
REQ-032 One sub-module sat_counter (increment, load-to-max, clear, saturate at DEPTH) implements count/full.
REQ-033 Stage storage is one array of DEPTH WIDTH-bit registers within param_shift_reg.

Verification
REQ-034 WIDTH=1, DEPTH=4, reset then sin=1, SHR x4 -> pout=4'b1111 after 4 edges, msb_out=1 at 4th, count 1,2,3,4, full=1.
REQ-035 WIDTH=8, DEPTH=4, LOAD pin=0x44332211, SHR rotate x1 -> pout=0x33221144, count=4; SHL rotate x1 -> 0x44332211.
REQ-036 Saturation: DEPTH=4, 6 SHR edges with sin=0xA5 -> count stays 4 after 4th edge, full=1 held.
REQ-037 flush with en=1, mode=LOAD same edge -> pout=0, count=0 (flush wins).
REQ-038 reset asserted during SHR stream with en=1 -> next cycle pout=0, count=0; en=0 cycles afterward -> no change.
REQ-039 DEPTH=1, WIDTH=4: SHL sin=0x9 -> lsb_out=msb_out=0x9, count=1, full=1; SHL rotate -> unchanged.
